if_stage_ctrl: RTL and testbench

Front-end pipeline controller that acts on the stall and bubble requests raised by the load-use hazard detector and the redirect requests from branch resolution. It owns the PC register and the IF/ID pipeline register (PC, instruction, valid). It counts stall, bubble and flush events and flags pathological stall runs and misaligned redirects. It sits between instruction memory and the decode stage.

---
 rtl/if_stage_ctrl_pkg.sv | 23 ++
 rtl/if_stage_ctrl_sat_counter.sv | 22 ++
 rtl/if_stage_ctrl.sv | 145 ++++++++++++++
 tb/tb_if_stage_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_ctrl_pkg.sv
// Shared front-end pipeline definitions.
//   XLEN_DEFAULT  : default datapath width for PC and branch target
//   NOP_INSTR_VAL : addi x0,x0,0, placed in IF/ID on reset and on flush
//   PC_INC        : sequential fetch stride in bytes
//   fetch_action_e: per-cycle decision of the front-end controller
package if_stage_ctrl_pkg;

  localparam int          XLEN_DEFAULT  = 32;
  localparam logic [31:0] NOP_INSTR_VAL = 32'h0000_0013;
  localparam int          PC_INC        = 4;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2
  } fetch_action_e;

  // A redirect target is misaligned when it is not a word address.
  function automatic logic target_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/if_stage_ctrl_sat_counter.sv
// Saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   cnt        : current count; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_stage_ctrl.sv
// Front-end pipeline controller. Owns the PC and the IF/ID register and
// applies redirect (flush), stall and advance requests with priority
// flush > stall > advance. Counts stall, bubble and flush events and raises
// sticky flags for over-long stall runs and misaligned redirects.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   pc_write        : 1 = PC advances by 4, 0 = PC holds
//   if_id_write     : 1 = IF/ID loads the fetched instruction, 0 = holds
//   id_ex_bubble    : bubble inserted into ID/EX this cycle (counted only)
//   branch_taken    : redirect request, overrides both write enables
//   branch_target   : redirect address (low two bits forced to zero)
//   imem_instr      : instruction memory data at address pc
//   pc              : current fetch address
//   if_id_pc/instr/valid : IF/ID pipeline register contents
//   stall_cnt, bubble_cnt, flush_cnt : saturating event counters
//   stall_err       : sticky, pc_write low for MAX_STALL consecutive cycles
//   misalign_err    : sticky, redirect seen with branch_target[1:0] != 0
module if_stage_ctrl
  import if_stage_ctrl_pkg::*;
#(
  parameter int               XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = NOP_INSTR_VAL,
  parameter int               CNT_W     = 16,
  parameter int               MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             id_ex_bubble,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [31:0]      imem_instr,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err,
  output logic             misalign_err
);

  localparam int              RUN_W   = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  fetch_action_e    action;
  logic             stall_cycle;
  logic [RUN_W-1:0] run_cnt;

  // PC decision. IF/ID has its own enable and is handled separately, so
  // the action only captures what happens to the PC and the counters.
  always_comb begin
    action = ACT_ADVANCE;
    if (branch_taken) begin
      action = ACT_FLUSH;
    end else if (!pc_write) begin
      action = ACT_STALL;
    end
  end

  assign stall_cycle = (action == ACT_STALL);

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (action)
        ACT_FLUSH:   pc <= {branch_target[XLEN-1:2], 2'b00};
        ACT_ADVANCE: pc <= pc + XLEN'(PC_INC);
        default:     pc <= pc;
      endcase
    end
  end

  // IF/ID register. A flush squashes the instruction even when the hazard
  // detector asked to hold IF/ID; if_id_pc still records the fetch PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      if_id_pc    <= pc;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (if_id_write) begin
      if_id_pc    <= pc;
      if_id_instr <= imem_instr;
      if_id_valid <= 1'b1;
    end
  end

  // Stall watchdog: counts consecutive stall cycles, saturating at
  // MAX_STALL. The flag is set on the edge where the run reaches MAX_STALL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt   <= '0;
      stall_err <= 1'b0;
    end else if (!stall_cycle) begin
      run_cnt <= '0;
    end else begin
      if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
      if (run_cnt >= (RUN_MAX - RUN_W'(1))) begin
        stall_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (branch_taken && target_misaligned(branch_target[1:0])) begin
      misalign_err <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_cycle),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (id_ex_bubble),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_taken),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl. Counters are built 4 bits wide so saturation is
// reachable in a short run. The driver applies one cycle of inputs, then
// pushes the hand-computed register snapshot expected after that edge; the
// monitor pops and compares on the following falling edge.
module tb_if_stage_ctrl;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] I_A   = 32'h00A0_0093;
  localparam logic [31:0] I_B   = 32'h0050_0193;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      ifpc;
    logic [31:0]      instr;
    logic             valid;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] fc;
    logic             se;
    logic             me;
  } snap_t;

  localparam int EXP_W = $bits(snap_t);

  logic             clk;
  logic             rst_n;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_target;
  logic [31:0]      imem_instr;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  if_id_pc;
  logic [31:0]      if_id_instr;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             stall_err;
  logic             misalign_err;

  logic [EXP_W-1:0] exp_q[$];
  int               checks;
  int               failures;
  event             mon_tick;

  if_stage_ctrl #(
    .XLEN      (XLEN),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W),
    .MAX_STALL (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_bubble  (id_ex_bubble),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_instr    (imem_instr),
    .pc            (pc),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt),
    .flush_cnt     (flush_cnt),
    .stall_err     (stall_err),
    .misalign_err  (misalign_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic pw, input logic iw, input logic bub,
                     input logic bt, input logic [31:0] tgt,
                     input logic [31:0] instr);
    pc_write      = pw;
    if_id_write   = iw;
    id_ex_bubble  = bub;
    branch_taken  = bt;
    branch_target = tgt;
    imem_instr    = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                              input logic [31:0] e_instr, input logic e_v,
                              input logic [CNT_W-1:0] e_sc, input logic [CNT_W-1:0] e_bc,
                              input logic [CNT_W-1:0] e_fc, input logic e_se,
                              input logic e_me);
    snap_t s;
    s.pc    = e_pc;
    s.ifpc  = e_ifpc;
    s.instr = e_instr;
    s.valid = e_v;
    s.sc    = e_sc;
    s.bc    = e_bc;
    s.fc    = e_fc;
    s.se    = e_se;
    s.me    = e_me;
    exp_q.push_back(EXP_W'(s));
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk or mon_tick) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = snap_t'(exp_q.pop_front());
      chk("pc",           pc,                  e.pc);
      chk("if_id_pc",     if_id_pc,            e.ifpc);
      chk("if_id_instr",  if_id_instr,         e.instr);
      chk("if_id_valid",  32'(if_id_valid),    32'(e.valid));
      chk("stall_cnt",    32'(stall_cnt),      32'(e.sc));
      chk("bubble_cnt",   32'(bubble_cnt),     32'(e.bc));
      chk("flush_cnt",    32'(flush_cnt),      32'(e.fc));
      chk("stall_err",    32'(stall_err),      32'(e.se));
      chk("misalign_err", 32'(misalign_err),   32'(e.me));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_instr    = I_A;

    // Reset values, then release away from the rising edge.
    repeat (2) @(posedge clk);
    #1;
    expect_state(32'h0, 32'h0, NOP, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Four advance cycles from PC 0.
    cyc(1, 1, 0, 0, 0, I_A); expect_state(32'h04, 32'h00, I_A, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, I_A); expect_state(32'h08, 32'h04, I_A, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, I_A); expect_state(32'h0C, 32'h08, I_A, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, I_A); expect_state(32'h10, 32'h0C, I_A, 1, 0, 0, 0, 0, 0);

    // Three-cycle stall, one bubble on the first stalled cycle.
    cyc(0, 0, 1, 0, 0, I_B); expect_state(32'h10, 32'h0C, I_A, 1, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, I_B); expect_state(32'h10, 32'h0C, I_A, 1, 2, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, I_B); expect_state(32'h10, 32'h0C, I_A, 1, 3, 1, 0, 0, 0);

    // Flush while the hazard detector still stalls: redirect wins.
    cyc(0, 0, 0, 1, 32'h100, I_B); expect_state(32'h100, 32'h10, NOP, 0, 3, 1, 1, 0, 0);

    // Target instruction arrives one edge later.
    cyc(1, 1, 0, 0, 0, I_B); expect_state(32'h104, 32'h100, I_B, 1, 3, 1, 1, 0, 0);

    // Eight consecutive stalls: stall_err rises only after the eighth edge.
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, 0, 0, I_A);
      expect_state(32'h104, 32'h100, I_B, 1, CNT_W'(3 + k), 1, 1, (k == 8), 0);
    end

    // Release; stall_err stays set.
    cyc(1, 1, 0, 0, 0, I_B); expect_state(32'h108, 32'h104, I_B, 1, 11, 1, 1, 1, 0);

    // Misaligned redirect with a bubble in the same cycle.
    cyc(1, 1, 1, 1, 32'h102, I_A); expect_state(32'h100, 32'h108, NOP, 0, 11, 2, 2, 1, 1);

    // Mismatched enables: PC moves while IF/ID holds, then the reverse.
    cyc(1, 0, 0, 0, 0, I_A); expect_state(32'h104, 32'h108, NOP, 0, 11, 2, 2, 1, 1);
    cyc(0, 1, 0, 0, 0, I_B); expect_state(32'h104, 32'h104, I_B, 1, 12, 2, 2, 1, 1);

    // Twenty more stalls: stall_cnt pins at 0xF.
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 0, 0, 0, I_A);
      expect_state(32'h104, 32'h104, I_B, 1, ((12 + k) > 15) ? 4'hF : CNT_W'(12 + k),
                   2, 2, 1, 1);
    end

    // Redirect to the top word, then advance across the wrap.
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, I_A);
    expect_state(32'hFFFF_FFFC, 32'h104, NOP, 0, 15, 2, 3, 1, 1);
    cyc(1, 1, 0, 0, 0, I_A);
    expect_state(32'h0000_0000, 32'hFFFF_FFFC, I_A, 1, 15, 2, 3, 1, 1);

    // Stall, then assert reset between rising edges.
    cyc(0, 0, 0, 0, 0, I_B);
    expect_state(32'h0000_0000, 32'hFFFF_FFFC, I_A, 1, 15, 2, 3, 1, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_state(32'h0, 32'h0, NOP, 0, 0, 0, 0, 0, 0);
    -> mon_tick;
    #1;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending expectations, required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
